// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by uart_rx (and by its peer uart_tx).
//   DATA_BITS       : payload width of one serial frame
//   uart_rx_state_t : receiver FSM states; PARITY only reachable when the
//                     receiver is built with UART_RX_PARITY_EN defined
//   even_parity()   : parity bit value that makes the total count of ones
//                     (data + parity) even
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial input and the received-byte outputs of uart_rx.
//   rx         : serial line, idle high (driven by the line / transmitter)
//   data       : last good byte
//   valid      : one-cycle strobe, byte completed with a good stop bit
//   frame_err  : one-cycle strobe, stop bit sampled low
//   busy       : receiver is inside a frame
//   parity_err : one-cycle strobe, parity mismatch (parity builds only)
// Modports:
//   master : line/consumer side (drives rx, observes results)
//   slave  : receiver side (uart_rx)
// ---------------------------------------------------------------------------
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;
  logic                 parity_err;

  modport master (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy,
    input  parity_err
  );

  modport slave (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy,
    output parity_err
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input bit.
// Parameters:
//   RESET_VAL : value both flops take while in reset
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output (2 cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The asynchronous rx line is synchronised, the start
// edge is qualified at mid start-bit, every following bit is sampled at
// mid-bit, and a completed byte is presented with a one-cycle valid strobe.
// A low stop bit raises frame_err once and the receiver then waits for the
// line to return high before accepting a new start edge.
//
// Build option: define UART_RX_PARITY_EN to receive an even-parity bit
// between bit 7 and the stop bit (8E1). A mismatch pulses parity_err instead
// of valid; data is still updated. Without the macro parity_err is 0.
//
// Parameters:
//   CLOCKS_PER_BIT : clk cycles per serial bit, must be >= 4
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_rx_if.slave (rx in; data/valid/frame_err/busy/parity_err out)
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.slave  bus
);

  if (CLOCKS_PER_BIT < 4) begin : g_bad_cfg
    $error("uart_rx: CLOCKS_PER_BIT must be >= 4");
  end

  localparam int CW   = $clog2(CLOCKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int HALF = CLOCKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t       state_reg,     state_next;
  logic [CW-1:0]        cnt_reg,       cnt_next;
  logic [IW-1:0]        bit_idx_reg,   bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg,     shift_next;
  logic [DATA_BITS-1:0] data_reg,      data_next;
  logic                 valid_reg,     valid_next;
  logic                 frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_reg,    par_bit_next;
  logic                 parity_err_reg, parity_err_next;
`endif

  logic half_done;
  logic bit_done;

  // All FSM decisions use the synchronised copy of rx only.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rx),
    .q     (rx_s)
  );

  assign half_done = (cnt_reg == HALF_LAST);
  assign bit_done  = (cnt_reg == BIT_LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        // High at mid start-bit means the falling edge was a glitch.
        if (half_done) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done && (bit_idx_reg == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
      STOP: begin
        // Returning to IDLE at mid-stop lets a back-to-back start edge in.
        if (bit_done) state_next = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output and datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_next       = cnt_reg + CW'(1);
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next    = par_bit_reg;
    parity_err_next = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
      end
      START: begin
        if (half_done) begin
          cnt_next     = '0;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};  // LSB first
          bit_idx_next = bit_idx_reg + IW'(1);
        end
      end
      PARITY: begin
        if (bit_done) begin
          cnt_next = '0;
`ifdef UART_RX_PARITY_EN
          par_bit_next = rx_s;
`endif
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next = shift_reg;
`ifdef UART_RX_PARITY_EN
            if (even_parity(shift_reg) == par_bit_reg) begin
              valid_next = 1'b1;
            end else begin
              parity_err_next = 1'b1;
            end
`else
            valid_next = 1'b1;
`endif
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_next = '0;
      end
      default: begin
        cnt_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      par_bit_reg    <= par_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  // valid is registered from the STOP sample, the same edge that returns the
  // FSM to IDLE, so busy falls in exactly the cycle valid is high.
  assign bus.data      = data_reg;
  assign bus.valid     = valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_reg;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx (CLOCKS_PER_BIT=10). A serial driver task
// plays the role of the transmitter; a negedge monitor counts strobes and
// records received bytes. Honours UART_RX_PARITY_EN for the parity steps.
// ---------------------------------------------------------------------------
`timescale 1ps/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB    = 10;
  localparam int CLK_PS = 10000;
  localparam int BIT_PS = CPB * CLK_PS;
  localparam int SLOW_PS = 103000;  // +3 % bit time
  localparam int FAST_PS = 97000;   // -3 % bit time

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_if rx_bus ();

  uart_rx #(
    .CLOCKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rx_bus)
  );

  always #(CLK_PS / 2) clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Monitor state
  int         cyc         = 0;
  int         valid_cnt   = 0;
  int         ferr_cnt    = 0;
  int         perr_cnt    = 0;
  int         busy_rise   = 0;
  int         overlap_cnt = 0;
  int         valid_cyc   = 0;
  logic       busy_prev   = 1'b0;
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_bus.valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
      rx_q.push_back(rx_bus.data);
      $display("[%0t] rx byte 0x%02h", $time, rx_bus.data);
    end
    if (rx_bus.frame_err) begin
      ferr_cnt <= ferr_cnt + 1;
      $display("[%0t] rx framing error", $time);
    end
    if (rx_bus.parity_err) begin
      perr_cnt <= perr_cnt + 1;
      $display("[%0t] rx parity error, data 0x%02h", $time, rx_bus.data);
    end
    if (rx_bus.valid && rx_bus.frame_err) overlap_cnt <= overlap_cnt + 1;
    if (rx_bus.busy && !busy_prev) busy_rise <= busy_rise + 1;
    busy_prev <= rx_bus.busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1000;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, optional parity, stop bit.
  // stop_low_bits > 0 holds the line low for that many bit times in place
  // of the stop bit before releasing it high.
  task automatic send_frame(input logic [7:0] b, input int bit_ps,
                            input int stop_low_bits, input logic par_flip);
    logic pbit;
    pbit = even_parity(b) ^ par_flip;
    $display("[%0t] tx byte 0x%02h bit_ps=%0d stop_low=%0d par=%0b", $time, b, bit_ps, stop_low_bits, pbit);
    rx_bus.rx = 1'b0;
    #(bit_ps);
    for (int i = 0; i < 8; i++) begin
      rx_bus.rx = b[i];
      #(bit_ps);
    end
`ifdef UART_RX_PARITY_EN
    rx_bus.rx = pbit;
    #(bit_ps);
`endif
    if (stop_low_bits > 0) begin
      rx_bus.rx = 1'b0;
      #(bit_ps * stop_low_bits);
    end
    rx_bus.rx = 1'b1;
    #(bit_ps);
  endtask

  initial begin
    int v0, f0, b0, p0, t0, lat;
    logic [7:0] c5;
    c5 = 8'hC5;

    rx_bus.rx = 1'b1;
    rst_n     = 1'b0;
    wait_cyc(3);

    // Reset state
    check("rst_data",       32'(rx_bus.data),       32'h00);
    check("rst_valid",      32'(rx_bus.valid),      32'h0);
    check("rst_frame_err",  32'(rx_bus.frame_err),  32'h0);
    check("rst_busy",       32'(rx_bus.busy),       32'h0);
    check("rst_parity_err", 32'(rx_bus.parity_err), 32'h0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Single byte 0x55
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_rise;
    align();
    t0 = cyc;
    send_frame(8'h55, BIT_PS, 0, 1'b0);
    wait_cyc(20);
    lat = valid_cyc - t0;
    check("u_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("u_data",        32'(rx_bus.data),    32'h55);
    check("u_frame_err",   32'(ferr_cnt - f0),  32'd0);
    check("u_busy_window", 32'(busy_rise - b0), 32'd1);
    check("u_busy_idle",   32'(rx_bus.busy),    32'd0);
    check("u_latency",     32'((lat >= 96) && (lat <= 98)), 32'd1);

    // Glitch shorter than half a bit
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_rise;
    align();
    rx_bus.rx = 1'b0;
    #(3 * CLK_PS);
    rx_bus.rx = 1'b1;
    wait_cyc(20);
    check("g_busy_pulse", 32'(busy_rise - b0), 32'd1);
    check("g_no_valid",   32'(valid_cnt - v0), 32'd0);
    check("g_no_ferr",    32'(ferr_cnt - f0),  32'd0);
    check("g_busy_idle",  32'(rx_bus.busy),    32'd0);
    v0 = valid_cnt;
    align();
    send_frame(8'hA3, BIT_PS, 0, 1'b0);
    wait_cyc(20);
    check("g_next_valid", 32'(valid_cnt - v0), 32'd1);
    check("g_next_data",  32'(rx_bus.data),    32'hA3);

    // Framing error: stop bit held low for two bit times
    v0 = valid_cnt; f0 = ferr_cnt;
    align();
    send_frame(8'h0F, BIT_PS, 2, 1'b0);
    wait_cyc(20);
    check("f_ferr_count", 32'(ferr_cnt - f0),  32'd1);
    check("f_no_valid",   32'(valid_cnt - v0), 32'd0);
    check("f_data_kept",  32'(rx_bus.data),    32'hA3);
    check("f_busy_idle",  32'(rx_bus.busy),    32'd0);
    v0 = valid_cnt;
    align();
    send_frame(8'h3C, BIT_PS, 0, 1'b0);
    wait_cyc(20);
    check("f_next_valid", 32'(valid_cnt - v0), 32'd1);
    check("f_next_data",  32'(rx_bus.data),    32'h3C);

    // Back-to-back, slow line
    rx_q.delete();
    v0 = valid_cnt;
    align();
    send_frame(8'h00, SLOW_PS, 0, 1'b0);
    send_frame(8'hFF, SLOW_PS, 0, 1'b0);
    send_frame(8'h81, SLOW_PS, 0, 1'b0);
    wait_cyc(20);
    check("bs_count", 32'(valid_cnt - v0), 32'd3);
    check("bs_q_size", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("bs_b0", 32'(rx_q[0]), 32'h00);
      check("bs_b1", 32'(rx_q[1]), 32'hFF);
      check("bs_b2", 32'(rx_q[2]), 32'h81);
    end

    // Back-to-back, fast line
    rx_q.delete();
    v0 = valid_cnt;
    align();
    send_frame(8'h00, FAST_PS, 0, 1'b0);
    send_frame(8'hFF, FAST_PS, 0, 1'b0);
    send_frame(8'h81, FAST_PS, 0, 1'b0);
    wait_cyc(20);
    check("bf_count", 32'(valid_cnt - v0), 32'd3);
    check("bf_q_size", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("bf_b0", 32'(rx_q[0]), 32'h00);
      check("bf_b1", 32'(rx_q[1]), 32'hFF);
      check("bf_b2", 32'(rx_q[2]), 32'h81);
    end

    // Reset in the middle of bit 4 of 0xC5
    v0 = valid_cnt;
    align();
    rx_bus.rx = 1'b0;
    #(BIT_PS);
    for (int i = 0; i < 4; i++) begin
      rx_bus.rx = c5[i];
      #(BIT_PS);
    end
    rx_bus.rx = c5[4];
    #(BIT_PS / 2);
    check("r_busy_before", 32'(rx_bus.busy), 32'd1);
    rst_n = 1'b0;
    #1000;
    check("r_data",       32'(rx_bus.data),       32'h00);
    check("r_valid",      32'(rx_bus.valid),      32'd0);
    check("r_frame_err",  32'(rx_bus.frame_err),  32'd0);
    check("r_busy",       32'(rx_bus.busy),       32'd0);
    check("r_parity_err", 32'(rx_bus.parity_err), 32'd0);
    rx_bus.rx = 1'b1;
    #(2 * BIT_PS);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(30);
    check("r_no_valid", 32'(valid_cnt - v0), 32'd0);
    align();
    send_frame(8'h5A, BIT_PS, 0, 1'b0);
    wait_cyc(20);
    check("r_next_valid", 32'(valid_cnt - v0), 32'd1);
    check("r_next_data",  32'(rx_bus.data),    32'h5A);

`ifdef UART_RX_PARITY_EN
    // Good parity then wrong parity on 0x07
    v0 = valid_cnt; p0 = perr_cnt;
    align();
    send_frame(8'h07, BIT_PS, 0, 1'b0);
    wait_cyc(20);
    check("p_good_valid", 32'(valid_cnt - v0), 32'd1);
    check("p_good_perr",  32'(perr_cnt - p0),  32'd0);
    check("p_good_data",  32'(rx_bus.data),    32'h07);
    v0 = valid_cnt; p0 = perr_cnt;
    align();
    send_frame(8'h07, BIT_PS, 0, 1'b1);
    wait_cyc(20);
    check("p_bad_valid", 32'(valid_cnt - v0), 32'd0);
    check("p_bad_perr",  32'(perr_cnt - p0),  32'd1);
    check("p_bad_data",  32'(rx_bus.data),    32'h07);
`else
    p0 = 0;
    check("p_tied_count", 32'(perr_cnt - p0), 32'd0);
    check("p_tied_level", 32'(rx_bus.parity_err), 32'd0);
`endif

    check("valid_ferr_overlap", 32'(overlap_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
